// File: rtl/spatz_id_tracker.sv
// spatz_id_tracker: hands out in-flight instruction IDs to decoded requests,
// remembers which execution unit owns each ID, and retires IDs on unit
// completion responses. Back-pressures the decoder when every ID is taken.

// Per-ID slot: in-flight bit plus owning unit.
module spatz_id_slot (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       alloc_i,
  input  logic [1:0] unit_i,
  input  logic       retire_i,
  output logic       busy_o,
  output logic [1:0] owner_o
);

  // Alloc only ever targets a free slot and retire only a busy one, so the
  // two never collide on the same slot.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      busy_o  <= 1'b0;
      owner_o <= 2'd0;
    end else if (alloc_i) begin
      busy_o  <= 1'b1;
      owner_o <= unit_i;
    end else if (retire_i) begin
      busy_o  <= 1'b0;
    end
  end

endmodule

module spatz_id_tracker #(
  parameter  int unsigned NrIds    = 4,
  localparam int unsigned IdWidth  = $clog2(NrIds),
  localparam int unsigned CntWidth = $clog2(NrIds + 1)
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                req_valid_i,
  input  logic [1:0]          req_unit_i,
  output logic                req_ready_o,
  output logic [IdWidth-1:0]  req_id_o,
  input  logic                vfu_rsp_valid_i,
  input  logic [IdWidth-1:0]  vfu_rsp_id_i,
  input  logic                vlsu_rsp_valid_i,
  input  logic [IdWidth-1:0]  vlsu_rsp_id_i,
  input  logic                vlsu_rsp_exc_i,
  input  logic                vsldu_rsp_valid_i,
  input  logic [IdWidth-1:0]  vsldu_rsp_id_i,
  input  logic                exc_clear_i,
  output logic [NrIds-1:0]    busy_o,
  output logic [3:0]          unit_busy_o,
  output logic [CntWidth-1:0] count_o,
  output logic                empty_o,
  output logic                exc_o,
  output logic                err_o
);

  typedef enum logic [1:0] {CON = 2'd0, LSU = 2'd1, SLD = 2'd2, VFU = 2'd3} ex_unit_e;

  logic [NrIds-1:0]      busy_q;
  logic [NrIds-1:0][1:0] owner_q;
  logic [CntWidth-1:0]   count_q, count_d, n_ret;
  logic                  exc_q, err_q;

  logic [NrIds-1:0]      alloc_vec, retire;
  logic [IdWidth-1:0]    alloc_id;
  logic                  is_con, accept;
  logic                  vfu_match, vlsu_match, vsldu_match;

  // Lowest free ID; free comes from registered state so a slot retiring this
  // cycle is not handed out until the next one.
  always_comb begin
    alloc_id = '0;
    for (int i = NrIds - 1; i >= 0; i--)
      if (!busy_q[i]) alloc_id = IdWidth'(i);
  end

  assign is_con      = (req_unit_i == CON);
  assign req_ready_o = is_con | ~(&busy_q);
  assign req_id_o    = alloc_id;
  assign accept      = req_valid_i & req_ready_o & ~is_con;

  // Match each response port against busy + owner; owners are unique per ID
  // so at most one port can retire a given slot.
  always_comb begin
    vfu_match   = 1'b0;
    vlsu_match  = 1'b0;
    vsldu_match = 1'b0;
    retire      = '0;
    alloc_vec   = '0;
    for (int i = 0; i < NrIds; i++) begin
      alloc_vec[i] = accept & (alloc_id == IdWidth'(i));
      if (vfu_rsp_valid_i && vfu_rsp_id_i == IdWidth'(i) && busy_q[i] && owner_q[i] == VFU) begin
        vfu_match = 1'b1;
        retire[i] = 1'b1;
      end
      if (vlsu_rsp_valid_i && vlsu_rsp_id_i == IdWidth'(i) && busy_q[i] && owner_q[i] == LSU) begin
        vlsu_match = 1'b1;
        retire[i]  = 1'b1;
      end
      if (vsldu_rsp_valid_i && vsldu_rsp_id_i == IdWidth'(i) && busy_q[i] && owner_q[i] == SLD) begin
        vsldu_match = 1'b1;
        retire[i]   = 1'b1;
      end
    end
  end

  assign n_ret   = CntWidth'(vfu_match) + CntWidth'(vlsu_match) + CntWidth'(vsldu_match);
  assign count_d = count_q + CntWidth'(accept) - n_ret;

  for (genvar g = 0; g < NrIds; g++) begin : g_slot
    spatz_id_slot u_slot (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .alloc_i  (alloc_vec[g]),
      .unit_i   (req_unit_i),
      .retire_i (retire[g]),
      .busy_o   (busy_q[g]),
      .owner_o  (owner_q[g])
    );
  end

  // Occupancy count, sticky exception (set beats clear), one-cycle error pulse.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_q <= '0;
      exc_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      if (vlsu_match && vlsu_rsp_exc_i) exc_q <= 1'b1;
      else if (exc_clear_i)             exc_q <= 1'b0;
      err_q <= (vfu_rsp_valid_i & ~vfu_match) | (vlsu_rsp_valid_i & ~vlsu_match) |
               (vsldu_rsp_valid_i & ~vsldu_match);
    end
  end

  // Per-unit outstanding flags; CON never owns an ID.
  always_comb begin
    unit_busy_o = '0;
    for (int i = 0; i < NrIds; i++)
      if (busy_q[i] && owner_q[i] != CON) unit_busy_o[owner_q[i]] = 1'b1;
  end

  assign busy_o  = busy_q;
  assign count_o = count_q;
  assign empty_o = (count_q == '0);
  assign exc_o   = exc_q;
  assign err_o   = err_q;

`ifndef SYNTHESIS
  // Count must track the busy vector; a granted ID must be free.
  always @(posedge clk_i) begin
    if (!rst_i) begin
      assert (count_q == CntWidth'($countones(busy_q)));
      assert (!(|(alloc_vec & busy_q)));
    end
  end
`endif

endmodule

// File: tb/tb_spatz_id_tracker.sv
// Directed bench for spatz_id_tracker: expected IDs go through a scoreboard
// queue when a request is driven and are popped when the grant is sampled.
module tb_spatz_id_tracker;

  localparam logic [1:0] CON = 2'd0, LSU = 2'd1, SLD = 2'd2, VFU = 2'd3;

  logic       clk = 1'b0, rst = 1'b1;
  logic       req_valid;
  logic [1:0] req_unit;
  logic       req_ready;
  logic [1:0] req_id;
  logic       vfu_v, vlsu_v, vlsu_exc, vsldu_v, exc_clear;
  logic [1:0] vfu_id, vlsu_id, vsldu_id;
  logic [3:0] busy, unit_busy;
  logic [2:0] count;
  logic       empty, exc, err;

  int total = 0, bad = 0;
  int exp_q[$];

  always #5 clk = ~clk;

  spatz_id_tracker dut (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid), .req_unit_i(req_unit),
    .req_ready_o(req_ready), .req_id_o(req_id),
    .vfu_rsp_valid_i(vfu_v), .vfu_rsp_id_i(vfu_id),
    .vlsu_rsp_valid_i(vlsu_v), .vlsu_rsp_id_i(vlsu_id), .vlsu_rsp_exc_i(vlsu_exc),
    .vsldu_rsp_valid_i(vsldu_v), .vsldu_rsp_id_i(vsldu_id),
    .exc_clear_i(exc_clear),
    .busy_o(busy), .unit_busy_o(unit_busy), .count_o(count),
    .empty_o(empty), .exc_o(exc), .err_o(err)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  task automatic idle();
    req_valid = 0; req_unit = CON;
    vfu_v = 0; vfu_id = 0; vlsu_v = 0; vlsu_id = 0; vlsu_exc = 0;
    vsldu_v = 0; vsldu_id = 0; exc_clear = 0;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  // Drive one non-CON request, check grant against the scoreboard, clock it in.
  task automatic issue(input logic [1:0] unit, input int exp_id, input string tag);
    req_valid = 1; req_unit = unit;
    exp_q.push_back(exp_id);
    #1;
    chk({tag, "_ready"}, 32'(req_ready), 32'd1);
    chk({tag, "_id"}, 32'(req_id), 32'(exp_q.pop_front()));
    step();
    req_valid = 0;
  endtask

  initial begin
    idle();
    #2;
    // reset state
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_ready", 32'(req_ready), 32'd1);
    chk("rst_id", 32'(req_id), 32'd0);
    chk("rst_ubusy", 32'(unit_busy), 32'h0);
    chk("rst_exc", 32'(exc), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    #10 rst = 0;
    step();

    // fill with four VFU requests
    for (int i = 0; i < 4; i++) issue(VFU, i, $sformatf("fill%0d", i));
    req_unit = VFU;
    #1;
    chk("full_busy", 32'(busy), 32'hf);
    chk("full_count", 32'(count), 32'd4);
    chk("full_ready", 32'(req_ready), 32'd0);
    chk("full_empty", 32'(empty), 32'd0);
    chk("full_ubusy", 32'(unit_busy), 32'h8);
    req_valid = 1; req_unit = CON;
    #1;
    chk("con_ready", 32'(req_ready), 32'd1);
    step();
    idle();
    chk("con_count", 32'(count), 32'd4);

    // retire id2 while full with an LSU request waiting
    vfu_v = 1; vfu_id = 2; req_valid = 1; req_unit = LSU;
    #1;
    chk("rf_ready0", 32'(req_ready), 32'd0);
    step();
    vfu_v = 0;
    chk("rf_busy", 32'(busy), 32'hb);
    chk("rf_count", 32'(count), 32'd3);
    issue(LSU, 2, "rf_alloc");
    idle();
    chk("rf_busy2", 32'(busy), 32'hf);
    chk("rf_ubusy", 32'(unit_busy), 32'ha);
    chk("rf_count2", 32'(count), 32'd4);

    // wrong owner: slide unit names VFU-owned id1
    vsldu_v = 1; vsldu_id = 1;
    step();
    idle();
    chk("wo_busy", 32'(busy), 32'hf);
    chk("wo_err", 32'(err), 32'd1);
    chk("wo_count", 32'(count), 32'd4);
    step();
    chk("wo_err_pulse", 32'(err), 32'd0);

    // exception from LSU id2
    vlsu_v = 1; vlsu_id = 2; vlsu_exc = 1;
    step();
    idle();
    chk("exc_set", 32'(exc), 32'd1);
    chk("exc_busy", 32'(busy), 32'hb);
    chk("exc_err", 32'(err), 32'd0);
    step();
    chk("exc_sticky", 32'(exc), 32'd1);
    exc_clear = 1;
    step();
    idle();
    chk("exc_clr", 32'(exc), 32'd0);

    // fresh start, then triple retire
    rst = 1; #2; rst = 0;
    step();
    chk("rst2_count", 32'(count), 32'd0);
    issue(VFU, 0, "t0");
    issue(LSU, 1, "t1");
    issue(SLD, 2, "t2");
    chk("tri_count0", 32'(count), 32'd3);
    chk("tri_ubusy", 32'(unit_busy), 32'he);
    vfu_v = 1; vfu_id = 0; vlsu_v = 1; vlsu_id = 1; vlsu_exc = 1;
    vsldu_v = 1; vsldu_id = 2; exc_clear = 1;
    step();
    idle();
    chk("tri_count", 32'(count), 32'd0);
    chk("tri_empty", 32'(empty), 32'd1);
    chk("tri_busy", 32'(busy), 32'h0);
    chk("tri_err", 32'(err), 32'd0);
    chk("tri_exc_setwins", 32'(exc), 32'd1);

    // response for a non-busy ID
    vfu_v = 1; vfu_id = 0;
    step();
    idle();
    chk("nb_err", 32'(err), 32'd1);
    chk("nb_count", 32'(count), 32'd0);

    // async reset with two IDs in flight
    issue(VFU, 0, "r0");
    issue(LSU, 1, "r1");
    chk("mid_count", 32'(count), 32'd2);
    req_unit = VFU;
    #2 rst = 1;
    #1;
    chk("async_busy", 32'(busy), 32'h0);
    chk("async_count", 32'(count), 32'd0);
    chk("async_empty", 32'(empty), 32'd1);
    chk("async_ready", 32'(req_ready), 32'd1);
    chk("async_id", 32'(req_id), 32'd0);
    chk("async_exc", 32'(exc), 32'd0);
    #1 rst = 0;
    vlsu_v = 1; vlsu_id = 1;
    step();
    idle();
    chk("post_rst_err", 32'(err), 32'd1);
    chk("post_rst_count", 32'(count), 32'd0);

    chk("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
